hazard_flush_ctrl: RTL and testbench
====================================

HAZARD_FLUSH_CTRL -- requirements
Module: hazard_flush_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have ports pr1_IR, pr2_IR  input  16 each  instruction words held in pipeline registers 1 and 2.
REQ-004 SHALL have port pc_mux_select  input  3  PC redirect source (0 none, 1 rb/pr3, 2 c/pr5, 3 m/pr2, 4 one/pr3, 5 h/pr2, 6 a/pr4).
REQ-005 SHALL have port PCWrite  output  1  PC register write enable.
REQ-006 SHALL have ports pr1_write, pr2_write  output  1 each  pipeline register 1/2 load enables.
REQ-007 SHALL have ports pr1_flush, pr2_flush, pr3_flush, pr4_flush  output  1 each  load NOP into that stage at the next posedge.
REQ-008 SHALL have ports lm_sm_valid  output  1, lm_sm_reg  output  3  current LM/SM transfer register index.

Function
REQ-009 SHALL decode redirects combinationally: pc_mux_select 3 or 5 -> pr1_flush; 1 or 4 -> pr1_flush, pr2_flush; 6 -> pr1..pr3_flush; 2 -> pr1..pr4_flush; 0 or 7 -> none.
REQ-010 SHALL detect load-use hazard: pr2 opcode LW and pr2_IR[11:9] equals a source field (RA and/or RB, per package source table) of the pr1 instruction.
REQ-011 SHALL, on load-use hazard, for exactly one cycle drive PCWrite=0, pr1_write=0, pr2_flush=1 (bubble), then release.
REQ-012 SHALL implement FSM IDLE/SEQ with an 8-bit remaining-mask register.
REQ-013 SHALL, in IDLE when pr1 opcode is LM or SM and pr1_IR[7:0]!=0, load mask=pr1_IR[7:0] and enter SEQ at next posedge.
REQ-014 SHALL, in SEQ, assert lm_sm_valid=1, lm_sm_reg=index of lowest set mask bit, clear that bit each cycle, and hold PCWrite=0, pr1_write=0.
REQ-015 SHALL return to IDLE on the cycle the last set bit is consumed; PCWrite and pr1_write reassert that same cycle.
REQ-016 SHALL treat LM/SM with empty list (imm8=0) as no stall, no SEQ entry, lm_sm_valid=0.
REQ-017 SHALL give priority: redirect flush > LM/SM sequence > load-use stall; any redirect that flushes pr1 aborts SEQ to IDLE and clears the mask at next posedge.
REQ-018 SHALL keep PCWrite=1 during any redirect (pc_mux_select 1-6) regardless of stall conditions.
REQ-019 SHALL drive pr2_write=1 except never gated by this block (reserved, constant 1).
REQ-020 SHALL, when no hazard/redirect/sequence, drive PCWrite=1, pr1_write=1, all flushes 0, lm_sm_valid=0, lm_sm_reg=0.

Reset
REQ-021 SHALL, while reset=1 at posedge, set FSM=IDLE, mask=0, stall flag=0.
REQ-022 SHALL, while reset=1, drive PCWrite=1, pr1_write=1, pr2_write=1, pr1..pr4_flush=1, lm_sm_valid=0, lm_sm_reg=0.
REQ-023 SHALL, on reset asserted mid-SEQ, abandon the sequence with no further lm_sm_valid pulses.

Configuration
REQ-024 SHALL compile load-use detection (REQ-010/011) only when macro LOAD_USE_STALL_EN is defined; without it, no load-use stall is generated and software inserts NOPs.

Structure
REQ-025 SHALL take opcode constants (ADD..JLR), pc_mux_select codes, NOP encoding (16'hF000) and per-opcode source-field table from shared package pipe_pkg.
REQ-026 SHALL instantiate one sub-module lsb_pick8 (8-bit lowest-set-bit index encoder, 3-bit out).

Verification
REQ-027 SHALL test reset: reset=1 one cycle -> all flushes 1, PCWrite=1; after release all flushes 0, lm_sm_valid=0.
REQ-028 SHALL test load-use: pr2_IR=16'h4240 (LW R1), pr1_IR=16'h0458 (ADD R2,R1,R3) -> one cycle PCWrite=0, pr1_write=0, pr2_flush=1; absent when LOAD_USE_STALL_EN undefined.
REQ-029 SHALL test LM sequence: pr1_IR=16'h6092 (list 1001_0010) -> lm_sm_reg 1,4,7 on three consecutive cycles with PCWrite=0, then PCWrite=1, lm_sm_valid=0.
REQ-030 SHALL test redirect decode: pc_mux_select=6 -> pr1/pr2/pr3_flush=1, pr4_flush=0; =2 -> all four flushes 1.
REQ-031 SHALL test abort: pc_mux_select=4 during second SEQ cycle of 16'h6092 -> pr1/pr2_flush=1, FSM IDLE next cycle, no reg-7 pulse.
REQ-032 SHALL test empty list: pr1_IR=16'h6000 -> no stall, lm_sm_valid stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg -- shared pipeline definitions
//
// Contents:
//   * Opcode constants ADD..JLR held in IR[15:12], and the NOP word 16'hF000.
//   * pc_mux_select redirect codes (pcsel_e).
//   * LM/SM sequencer state encoding (lmsm_state_e).
//   * Per-opcode source-field table (src_fields): which of RA (IR[11:9]) and
//     RB (IR[8:6]) an instruction reads as a register operand.
//   * redirect_flush: maps a redirect code to the pipeline stages it kills.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADI = 4'h1;
    localparam logic [3:0] OP_NDU = 4'h2;
    localparam logic [3:0] OP_LHI = 4'h3;
    localparam logic [3:0] OP_LW  = 4'h4;
    localparam logic [3:0] OP_SW  = 4'h5;
    localparam logic [3:0] OP_LM  = 4'h6;
    localparam logic [3:0] OP_SM  = 4'h7;
    localparam logic [3:0] OP_JAL = 4'h8;
    localparam logic [3:0] OP_JLR = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_NOP = 4'hF;

    localparam logic [15:0] NOP_IR = 16'hF000;

    // Source of the next PC; anything other than NONE (and the unused 7)
    // is a taken redirect that kills younger instructions.
    typedef enum logic [2:0] {
        PCSEL_NONE = 3'd0,  // sequential fetch
        PCSEL_RB   = 3'd1,  // register target, resolved in pr3
        PCSEL_C    = 3'd2,  // PC written back, resolved in pr5
        PCSEL_M    = 3'd3,  // JAL target, resolved in pr2
        PCSEL_ONE  = 3'd4,  // branch target, resolved in pr3
        PCSEL_H    = 3'd5,  // alternate target, resolved in pr2
        PCSEL_A    = 3'd6   // ALU target, resolved in pr4
    } pcsel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } lmsm_state_e;

    typedef struct packed {
        logic ra;   // reads IR[11:9]
        logic rb;   // reads IR[8:6]
    } src_use_t;

    // Register operands read by each opcode.
    function automatic src_use_t src_fields(input logic [3:0] op);
        src_use_t s;
        s = '{ra: 1'b0, rb: 1'b0};
        case (op)
            OP_ADD, OP_NDU, OP_SW, OP_BEQ: s = '{ra: 1'b1, rb: 1'b1};
            OP_ADI, OP_LM, OP_SM:          s = '{ra: 1'b1, rb: 1'b0};
            OP_LW, OP_JLR:                 s = '{ra: 1'b0, rb: 1'b1};
            default:                       s = '{ra: 1'b0, rb: 1'b0};
        endcase
        return s;
    endfunction

    // Stages to flush for a redirect, returned as {pr4, pr3, pr2, pr1}.
    // The later the redirect resolves, the more younger stages it kills.
    function automatic logic [3:0] redirect_flush(input logic [2:0] sel);
        logic [3:0] f;
        case (sel)
            PCSEL_M, PCSEL_H:    f = 4'b0001;
            PCSEL_RB, PCSEL_ONE: f = 4'b0011;
            PCSEL_A:             f = 4'b0111;
            PCSEL_C:             f = 4'b1111;
            default:             f = 4'b0000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/hazard_flush_ctrl_lsb_pick8.sv
// -----------------------------------------------------------------------------
// lsb_pick8 -- lowest-set-bit index encoder, 8 bits in, 3-bit index out.
//
// Ports:
//   in_i  [7:0]  input vector
//   idx_o [2:0]  index of the lowest set bit of in_i; 0 when in_i is 0
// -----------------------------------------------------------------------------
module lsb_pick8 (
    input  logic [7:0] in_i,
    output logic [2:0] idx_o
);

    // Scan from the top down so the last match written is the lowest bit.
    always_comb begin
        idx_o = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (in_i[i]) idx_o = 3'(i);
        end
    end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_flush_ctrl -- pipeline stall / flush controller
//
// Generates the PC and pipeline-register write enables and per-stage flushes
// for a 16-bit in-order pipeline:
//   * control-transfer redirects flush younger stages (highest priority),
//   * LM/SM multi-register transfers are expanded into one register per cycle
//     by an IDLE/SEQ sequencer that walks the 8-bit register list,
//   * load-use hazards insert a one-cycle bubble (compile option).
//
// Ports:
//   clk            clock, all state on posedge
//   reset          synchronous, active-high
//   pr1_IR, pr2_IR instruction words in pipeline registers 1 and 2
//   pc_mux_select  redirect source code (pipe_pkg::pcsel_e)
//   PCWrite        PC write enable
//   pr1_write      pipeline register 1 load enable
//   pr2_write      pipeline register 2 load enable (always 1)
//   pr1..4_flush   load NOP into that stage at the next posedge
//   lm_sm_valid    a LM/SM transfer register is being issued this cycle
//   lm_sm_reg      index of that register
//
// Build option:
//   LOAD_USE_STALL_EN  when defined, a LW in pr2 whose destination is read by
//                      the instruction in pr1 stalls fetch for one cycle and
//                      bubbles pr2. When undefined, software schedules NOPs.
// -----------------------------------------------------------------------------
module hazard_flush_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pr1_IR,
    input  logic [15:0] pr2_IR,
    input  logic [2:0]  pc_mux_select,
    output logic        PCWrite,
    output logic        pr1_write,
    output logic        pr2_write,
    output logic        pr1_flush,
    output logic        pr2_flush,
    output logic        pr3_flush,
    output logic        pr4_flush,
    output logic        lm_sm_valid,
    output logic [2:0]  lm_sm_reg
);

    lmsm_state_e state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic        stall_q, stall_d;

    logic [3:0]  op1;
    logic [3:0]  redir_flush;
    logic        redirect;
    logic        hazard;
    logic [2:0]  pick_idx;
    logic [7:0]  mask_rest;
    logic [3:0]  flush;

    assign op1         = pr1_IR[15:12];
    assign redir_flush = redirect_flush(pc_mux_select);
    // Every redirect kills pr1, so a pr1 flush means "redirect taken".
    assign redirect    = redir_flush[0];
    // Remaining list once the lowest register has been issued.
    assign mask_rest   = mask_q & (mask_q - 8'd1);

    lsb_pick8 u_pick (
        .in_i  (mask_q),
        .idx_o (pick_idx)
    );

`ifdef LOAD_USE_STALL_EN
    src_use_t src1;
    logic     unused_ir;

    always_comb src1 = src_fields(op1);

    assign hazard = (pr2_IR[15:12] == OP_LW) &&
                    ((src1.ra && (pr2_IR[11:9] == pr1_IR[11:9])) ||
                     (src1.rb && (pr2_IR[11:9] == pr1_IR[8:6])));
    assign unused_ir = ^pr2_IR[8:0];
`else
    logic unused_ir;

    assign hazard    = 1'b0;
    assign unused_ir = ^{pr2_IR, pr1_IR[11:8]};
`endif

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        stall_d     = 1'b0;
        PCWrite     = 1'b1;
        pr1_write   = 1'b1;
        pr2_write   = 1'b1;
        flush       = redir_flush;
        lm_sm_valid = 1'b0;
        lm_sm_reg   = 3'd0;

        if (reset) begin
            // Hold the whole pipe at NOP while in reset.
            flush   = 4'b1111;
            state_d = ST_IDLE;
            mask_d  = 8'd0;
        end else if (redirect) begin
            // Redirect wins: PC keeps loading the target, any sequence dies.
            state_d = ST_IDLE;
            mask_d  = 8'd0;
        end else if (state_q == ST_SEQ) begin
            lm_sm_valid = 1'b1;
            lm_sm_reg   = pick_idx;
            PCWrite     = 1'b0;
            pr1_write   = 1'b0;
            mask_d      = mask_rest;
            if (mask_rest == 8'd0) state_d = ST_IDLE;
        end else if (hazard && !stall_q) begin
            // One bubble only: stall_q blocks a repeat on the next cycle,
            // by which time the LW has moved past the consumer.
            PCWrite   = 1'b0;
            pr1_write = 1'b0;
            flush[1]  = 1'b1;
            stall_d   = 1'b1;
        end else if (((op1 == OP_LM) || (op1 == OP_SM)) && (pr1_IR[7:0] != 8'd0)) begin
            // An empty list is a plain single-cycle instruction.
            state_d = ST_SEQ;
            mask_d  = pr1_IR[7:0];
        end
    end

    assign pr1_flush = flush[0];
    assign pr2_flush = flush[1];
    assign pr3_flush = flush[2];
    assign pr4_flush = flush[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= 8'd0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
module tb_hazard_flush_ctrl;

`ifdef LOAD_USE_STALL_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pr1_IR, pr2_IR;
    logic [2:0]  pc_mux_select;
    logic        PCWrite, pr1_write, pr2_write;
    logic        pr1_flush, pr2_flush, pr3_flush, pr4_flush;
    logic        lm_sm_valid;
    logic [2:0]  lm_sm_reg;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: registers still to be issued, in order, and
    // whether the previous cycle was a load-use bubble.
    int m_pend[$];
    bit m_stalled;

    hazard_flush_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pr1_IR        (pr1_IR),
        .pr2_IR        (pr2_IR),
        .pc_mux_select (pc_mux_select),
        .PCWrite       (PCWrite),
        .pr1_write     (pr1_write),
        .pr2_write     (pr2_write),
        .pr1_flush     (pr1_flush),
        .pr2_flush     (pr2_flush),
        .pr3_flush     (pr3_flush),
        .pr4_flush     (pr4_flush),
        .lm_sm_valid   (lm_sm_valid),
        .lm_sm_reg     (lm_sm_reg)
    );

    always #5 clk = ~clk;

    wire [10:0] obs_v = {PCWrite, pr1_write, pr2_write,
                         pr4_flush, pr3_flush, pr2_flush, pr1_flush,
                         lm_sm_valid, lm_sm_reg};

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Does instruction ir read register r as an operand?
    function automatic bit reads_reg(input logic [15:0] ir, input logic [2:0] r);
        bit ra, rb;
        ra = 1'b0;
        rb = 1'b0;
        case (ir[15:12])
            4'h0, 4'h2, 4'h5, 4'hC: begin ra = 1'b1; rb = 1'b1; end
            4'h1, 4'h6, 4'h7:       ra = 1'b1;
            4'h4, 4'h9:             rb = 1'b1;
            default: ;
        endcase
        return (ra && ir[11:9] == r) || (rb && ir[8:6] == r);
    endfunction

    // Apply one cycle of inputs, predict outputs, compare, advance model.
    task automatic step(input bit rst, input logic [15:0] i1, input logic [15:0] i2,
                        input logic [2:0] sel, input string tag);
        logic       pcw, p1w, vld;
        logic [3:0] fl;
        logic [2:0] rg;
        @(negedge clk);
        reset         = rst;
        pr1_IR        = i1;
        pr2_IR        = i2;
        pc_mux_select = sel;
        #1;
        pcw = 1'b1; p1w = 1'b1; vld = 1'b0; rg = 3'd0; fl = 4'b0000;
        if (rst) begin
            fl = 4'b1111;
            m_pend.delete();
            m_stalled = 1'b0;
        end else begin
            case (sel)
                3'd3, 3'd5: fl = 4'b0001;
                3'd1, 3'd4: fl = 4'b0011;
                3'd6:       fl = 4'b0111;
                3'd2:       fl = 4'b1111;
                default:    fl = 4'b0000;
            endcase
            if (sel >= 3'd1 && sel <= 3'd6) begin
                m_pend.delete();
                m_stalled = 1'b0;
            end else if (m_pend.size() > 0) begin
                vld = 1'b1;
                rg  = 3'(m_pend.pop_front());
                pcw = 1'b0;
                p1w = 1'b0;
                m_stalled = 1'b0;
            end else if (LU_EN && i2[15:12] == 4'h4 && reads_reg(i1, i2[11:9]) && !m_stalled) begin
                pcw = 1'b0;
                p1w = 1'b0;
                fl[1] = 1'b1;
                m_stalled = 1'b1;
            end else begin
                m_stalled = 1'b0;
                if ((i1[15:12] == 4'h6 || i1[15:12] == 4'h7) && i1[7:0] != 8'd0)
                    for (int b = 0; b < 8; b++)
                        if (i1[b]) m_pend.push_back(b);
            end
        end
        chk(tag, obs_v, {pcw, p1w, 1'b1, fl, vld, rg});
    endtask

    localparam logic [15:0] NOP = 16'hF000;

    initial begin
        logic [3:0]  ops [10];
        logic [15:0] a, b;
        logic [2:0]  s;
        bit          r;
        ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hC, 4'hF};

        reset = 1'b1; pr1_IR = NOP; pr2_IR = NOP; pc_mux_select = 3'd0;
        m_stalled = 1'b0;

        // Reset
        step(1, NOP, NOP, 0, "reset");
        chk("reset_flush", 11'({pr4_flush, pr3_flush, pr2_flush, pr1_flush}), 11'(4'b1111));
        chk("reset_pcw", 11'(PCWrite), 11'(1'b1));
        step(0, NOP, NOP, 0, "idle");
        chk("idle_flush", 11'({pr4_flush, pr3_flush, pr2_flush, pr1_flush, lm_sm_valid}), 11'(0));

        // Load-use
        step(0, 16'h0458, 16'h4240, 0, "lu_hit");
        chk("lu_pcw", 11'({PCWrite, pr1_write, pr2_flush}), LU_EN ? 11'(3'b001) : 11'(3'b110));
        step(0, 16'h0458, NOP, 0, "lu_release");
        chk("lu_release_pcw", 11'({PCWrite, pr1_write, pr2_flush}), 11'(3'b110));

        // LM 1001_0010 -> registers 1, 4, 7
        step(0, 16'h6092, NOP, 0, "lm_detect");
        step(0, NOP, NOP, 0, "lm_r1");
        chk("lm_r1_exp", 11'({lm_sm_valid, lm_sm_reg, PCWrite}), 11'({1'b1, 3'd1, 1'b0}));
        step(0, NOP, NOP, 0, "lm_r4");
        chk("lm_r4_exp", 11'({lm_sm_valid, lm_sm_reg, PCWrite}), 11'({1'b1, 3'd4, 1'b0}));
        step(0, NOP, NOP, 0, "lm_r7");
        chk("lm_r7_exp", 11'({lm_sm_valid, lm_sm_reg, PCWrite}), 11'({1'b1, 3'd7, 1'b0}));
        step(0, NOP, NOP, 0, "lm_done");
        chk("lm_done_exp", 11'({lm_sm_valid, PCWrite, pr1_write}), 11'(3'b011));

        // Redirect decode
        step(0, NOP, NOP, 6, "redir6");
        chk("redir6_fl", 11'({pr4_flush, pr3_flush, pr2_flush, pr1_flush}), 11'(4'b0111));
        step(0, NOP, NOP, 2, "redir2");
        chk("redir2_fl", 11'({pr4_flush, pr3_flush, pr2_flush, pr1_flush}), 11'(4'b1111));
        step(0, NOP, NOP, 3, "redir3");
        step(0, NOP, NOP, 1, "redir1");
        step(0, NOP, NOP, 5, "redir5");
        step(0, NOP, NOP, 7, "redir7");

        // Abort during the second SEQ cycle
        step(0, 16'h6092, NOP, 0, "ab_detect");
        step(0, NOP, NOP, 0, "ab_r1");
        step(0, NOP, NOP, 4, "ab_redirect");
        chk("ab_fl", 11'({pr2_flush, pr1_flush, PCWrite, lm_sm_valid}), 11'(4'b1110));
        step(0, NOP, NOP, 0, "ab_after");
        chk("ab_no_r7", 11'({lm_sm_valid, PCWrite}), 11'(2'b01));

        // Empty list
        step(0, 16'h6000, NOP, 0, "empty");
        chk("empty_pcw", 11'({PCWrite, pr1_write, lm_sm_valid}), 11'(3'b110));
        step(0, NOP, NOP, 0, "empty_after");
        chk("empty_vld", 11'(lm_sm_valid), 11'(1'b0));

        // Reset in the middle of a sequence
        step(0, 16'h70FF, NOP, 0, "rs_detect");
        step(0, NOP, NOP, 0, "rs_r0");
        step(1, NOP, NOP, 0, "rs_reset");
        step(0, NOP, NOP, 0, "rs_after");
        chk("rs_no_pulse", 11'(lm_sm_valid), 11'(1'b0));

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            a = 16'($urandom);
            a[15:12] = ops[$urandom_range(0, 9)];
            a[11:6]  = {1'b0, 2'($urandom_range(0, 3)), 1'b0, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'd0;
            b = 16'($urandom);
            b[15:12] = ($urandom_range(0, 1) == 0) ? 4'h4 : ops[$urandom_range(0, 9)];
            b[11:9]  = 3'($urandom_range(0, 3));
            step(r, a, b, s, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
